// File: rtl/param_burst_memory.sv
// Behavioural burst-mode main memory with an open-page latency model.
// Serves whole cache lines as BURST_LEN 64-bit beats after a page-hit or page-miss delay.
module param_burst_memory #(
  parameter int    DELAY      = 50,
  parameter int    DELAY_PAGE = 25,
  parameter int    BURST_LEN  = 4,
  parameter int    LINE_BITS  = 256,
  parameter int    PAGE_BYTES = 512,
  parameter int    MEM_LINES  = 2**20,
  parameter string INIT_FILE  = "memory.lst"
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] address,
  input  logic [63:0] burst_i,
  output logic [63:0] burst_o,
  output logic        resp
);

  localparam int LINE_BYTES = LINE_BITS / 8;
  localparam int OFFS       = $clog2(LINE_BYTES);
  localparam int PAGE_SH    = $clog2(PAGE_BYTES);
  localparam int IDX_W      = (MEM_LINES > 1) ? $clog2(MEM_LINES) : 1;
  localparam int BW         = IDX_W + OFFS;
  localparam int MEM_BYTES  = MEM_LINES * LINE_BYTES;
  localparam int CNT_W      = (DELAY > 1) ? $clog2(DELAY) : 1;
  localparam int BEAT_W     = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int PG_W       = 32 - PAGE_SH;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_BURST = 2'd2;

  // Byte-wide storage so the little-endian, byte-addressed image maps directly.
  logic [7:0] mem [MEM_BYTES];

  logic [1:0]        state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [BEAT_W-1:0] beat_q;
  logic [IDX_W-1:0]  line_q;
  logic              op_read_q;
  logic [PG_W-1:0]   page_q;
  logic              page_valid_q;

  logic              page_hit;
  logic [BW-1:0]     beat_base;
  logic [63:0]       beat_data;
  logic              unused_addr;

  assign page_hit  = page_valid_q && (page_q == address[31:PAGE_SH]);
  assign beat_base = {line_q, {OFFS{1'b0}}} | (BW'(beat_q) << 3);
  assign unused_addr = ^address;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      page_valid_q <= 1'b0;
      cnt_q        <= '0;
      beat_q       <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (read || write) begin
            line_q       <= address[OFFS +: IDX_W];
            op_read_q    <= read;
            page_q       <= address[31:PAGE_SH];
            page_valid_q <= 1'b1;
            cnt_q        <= page_hit ? CNT_W'(DELAY_PAGE - 1) : CNT_W'(DELAY - 1);
            state_q      <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt_q == '0) begin
            state_q <= S_BURST;
            beat_q  <= '0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_BURST: begin
          if (beat_q == BEAT_W'(BURST_LEN - 1)) begin
            state_q <= S_IDLE;
          end else begin
            beat_q <= beat_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Write beats land on the edge that ends each resp cycle; reset never clears storage.
  always_ff @(posedge clk) begin
    if (!rst && state_q == S_BURST && !op_read_q) begin
      for (int i = 0; i < 8; i++) begin
        mem[beat_base | BW'(i)] <= burst_i[8*i +: 8];
      end
    end
  end

  always_comb begin
    beat_data = '0;
    for (int i = 0; i < 8; i++) begin
      beat_data[8*i +: 8] = mem[beat_base | BW'(i)];
    end
  end

  assign resp    = (state_q == S_BURST);
  assign burst_o = (resp && op_read_q) ? beat_data : 64'd0;

endmodule

// File: tb/tb_param_burst_memory.sv
// Scoreboard bench for param_burst_memory: latency per page state, beat data, reset abort,
// read-over-write priority, coherence and address aliasing.
module tb_param_burst_memory;

  localparam int LINES = 256;
  localparam int BYTES = LINES * 32;

  logic        clk;
  logic        rst;
  logic        read;
  logic        write;
  logic [31:0] address;
  logic [63:0] burst_i;
  logic [63:0] burst_o;
  logic        resp;

  int total = 0;
  int bad   = 0;

  logic [7:0]  model [BYTES];
  logic [63:0] exp_q [$];
  logic [63:0] wbeats [4];

  param_burst_memory #(
    .DELAY(50), .DELAY_PAGE(25), .BURST_LEN(4), .LINE_BITS(256),
    .PAGE_BYTES(512), .MEM_LINES(LINES), .INIT_FILE("")
  ) dut (
    .clk(clk), .rst(rst), .read(read), .write(write), .address(address),
    .burst_i(burst_i), .burst_o(burst_o), .resp(resp)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Preload the same byte pattern into the DUT and the reference image.
  initial begin
    for (int i = 0; i < BYTES; i++) begin
      dut.mem[i] <= 8'(i);
      model[i] = 8'(i);
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int line_base(input logic [31:0] addr);
    return ((int'(addr >> 5)) % LINES) * 32;
  endfunction

  task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] addr,
                               input int exp_lat, input string tag);
    int cycles;
    int base;
    logic [63:0] beat;
    @(negedge clk);
    read    = rd;
    write   = wr;
    address = addr;
    base    = line_base(addr);
    if (rd) begin
      for (int b = 0; b < 4; b++) begin
        for (int i = 0; i < 8; i++) beat[8*i +: 8] = model[base + b*8 + i];
        exp_q.push_back(beat);
      end
    end else if (wr) begin
      for (int b = 0; b < 4; b++)
        for (int i = 0; i < 8; i++) model[base + b*8 + i] = wbeats[b][8*i +: 8];
    end
    @(posedge clk);
    #1 address = ~addr;
    cycles = 0;
    do begin
      @(posedge clk);
      cycles++;
      @(negedge clk);
    end while (!resp && cycles < 200);
    if (!resp) begin
      checkOutput({tag, "_timeout"}, 64'd0, 64'd1);
      read  = 1'b0;
      write = 1'b0;
      exp_q.delete();
      return;
    end
    checkOutput({tag, "_lat"}, 64'(cycles), 64'(exp_lat));
    for (int b = 0; b < 4; b++) begin
      if (b > 0) checkOutput({tag, "_resp"}, {63'd0, resp}, 64'd1);
      if (rd) begin
        if (exp_q.size() == 0) checkOutput({tag, "_empty"}, 64'd0, 64'd1);
        else checkOutput({tag, "_data"}, burst_o, exp_q.pop_front());
      end
      if (wr) burst_i = wbeats[b];
      if (b == 1) begin
        read  = 1'b0;
        write = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
    end
    checkOutput({tag, "_end"}, {63'd0, resp}, 64'd0);
    read  = 1'b0;
    write = 1'b0;
  endtask

  initial begin
    bit seen;
    rst     = 1'b1;
    read    = 1'b0;
    write   = 1'b0;
    address = 32'd0;
    burst_i = 64'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_resp", {63'd0, resp}, 64'd0);
    checkOutput("rst_burst", burst_o, 64'd0);
    rst = 1'b0;

    applyStimulus(1'b1, 1'b0, 32'h0000_0000, 50, "t1");
    applyStimulus(1'b1, 1'b0, 32'h0000_0020, 25, "t2");
    applyStimulus(1'b1, 1'b0, 32'h0000_0200, 50, "t3a");
    applyStimulus(1'b1, 1'b0, 32'h0000_0000, 50, "t3b");

    wbeats[0] = 64'h1111_1111_1111_1111;
    wbeats[1] = 64'h2222_2222_2222_2222;
    wbeats[2] = 64'h3333_3333_3333_3333;
    wbeats[3] = 64'h4444_4444_4444_4444;
    applyStimulus(1'b0, 1'b1, 32'h0000_1000, 50, "t4w");
    applyStimulus(1'b1, 1'b0, 32'h0000_1000, 25, "t4r");

    @(negedge clk);
    read    = 1'b1;
    address = 32'h0000_0000;
    @(posedge clk);
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst  = 1'b1;
    read = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst  = 1'b0;
    seen = 1'b0;
    checkOutput("t5_resp_rst", {63'd0, resp}, 64'd0);
    repeat (60) begin
      @(negedge clk);
      if (resp) seen = 1'b1;
    end
    checkOutput("t5_abort", {63'd0, seen}, 64'd0);
    applyStimulus(1'b1, 1'b0, 32'h0000_0000, 50, "t5r");

    wbeats[0] = 64'hDEAD_BEEF_0000_0001;
    wbeats[1] = 64'hDEAD_BEEF_0000_0002;
    wbeats[2] = 64'hDEAD_BEEF_0000_0003;
    wbeats[3] = 64'hDEAD_BEEF_0000_0004;
    applyStimulus(1'b1, 1'b1, 32'h0000_0040, 25, "t6rw");
    applyStimulus(1'b1, 1'b0, 32'h0000_0040, 25, "t6r");

    applyStimulus(1'b1, 1'b0, 32'h0000_2000, 50, "alias_r");
    wbeats[0] = 64'h0123_4567_89AB_CDEF;
    wbeats[1] = 64'hFEDC_BA98_7654_3210;
    wbeats[2] = 64'hA5A5_5A5A_A5A5_5A5A;
    wbeats[3] = 64'h0F0F_F0F0_0F0F_F0F0;
    applyStimulus(1'b0, 1'b1, 32'h0000_2020, 25, "alias_w");
    applyStimulus(1'b1, 1'b0, 32'h0000_0020, 50, "alias_rb");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
